// File: rtl/light_cmd_parser_pkg.sv
// Shared definitions for the light command frame parser: frame framing bytes,
// response bytes, known command codes, error codes and FSM state encoding.
package light_cmd_parser_pkg;

  localparam logic [7:0] BYTE_SOF = 8'h4B;
  localparam logic [7:0] BYTE_EOF = 8'h0D;
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  // Command codes seen on the link; carried through untouched, decoded downstream.
  localparam logic [7:0] CMD_INIT   = 8'h00;
  localparam logic [7:0] CMD_ENABLE = 8'h02;
  localparam logic [7:0] CMD_INC    = 8'h0A;
  localparam logic [7:0] CMD_DEC    = 8'h12;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TERM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_TERM = 3'd4
  } state_e;

  // LEN field holds (byte count - 1); the reported length is the real count.
  function automatic logic [3:0] len_from_l(input logic [2:0] l);
    return {1'b0, l} + 4'd1;
  endfunction

endpackage

// File: rtl/light_cmd_timeout.sv
// Inter-byte timeout counter.
//  i_clk, i_rst_n : clock, asynchronous active-low reset
//  i_clr          : restart the count (a byte arrived)
//  i_en           : count enable; counter is held at zero while low
//  o_expire       : combinational, high in the cycle whose clock edge would
//                   bring the count to g_LIMIT (suppressed when i_clr is high)
module light_cmd_timeout #(
  parameter int unsigned g_LIMIT = 1200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = $clog2(g_LIMIT + 1);
  localparam logic [W-1:0] LIMIT_V = W'(g_LIMIT);
  localparam logic [W-1:0] LAST_V  = W'(g_LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || !i_en) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT_V) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // A byte arriving in the expiry cycle restarts the count instead.
  assign o_expire = i_en && !i_clr && (cnt_q == LAST_V);

endmodule

// File: rtl/light_cmd_parser.sv
// Frame decoder between the UART receiver and the PWM command registers.
// Frame: 0x4B | CMD | LEN | LEN+1 payload bytes | 0x0D.
//  i_clk, i_rst_n        : clock, asynchronous active-low reset
//  i_rx_data, i_rx_vld   : received byte and its one-cycle strobe
//  o_cmd_vld             : one-cycle strobe for a complete valid frame
//  o_cmd, o_len          : command code and payload byte count (held)
//  o_payload             : little-endian payload, unused bytes zero (held)
//  o_err, o_err_code     : abort strobe; code 1 bad LEN, 2 bad terminator,
//                          3 timeout (code held until the next abort)
//  o_tx_data, o_tx_start : ACK/NAK byte and one-cycle transmit request
//  i_tx_busy             : transmitter busy
module light_cmd_parser
  import light_cmd_parser_pkg::*;
#(
  parameter int unsigned g_CLK_FREQ      = 30_000_000,
  parameter int unsigned g_BAUD_RATE     = 1_000_000,
  parameter int unsigned g_TIMEOUT_BYTES = 4,
  parameter int unsigned g_MAX_PAYLOAD   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_vld,
  output logic        o_cmd_vld,
  output logic [7:0]  o_cmd,
  output logic [3:0]  o_len,
  output logic [63:0] o_payload,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_busy
);

  // Each byte-time is 10 bit-times (start + 8 data + stop).
  localparam int unsigned TLIM = 32'((64'(g_TIMEOUT_BYTES) * 64'd10 * 64'(g_CLK_FREQ))
                                     / 64'(g_BAUD_RATE));

  state_e       state_q, state_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [2:0]   lmax_q, lmax_d;
  logic [2:0]   idx_q, idx_d;
  logic [63:0]  shreg_q, shreg_d;

  logic         cmd_vld_q, cmd_vld_d;
  logic [7:0]   out_cmd_q, out_cmd_d;
  logic [3:0]   out_len_q, out_len_d;
  logic [63:0]  out_pay_q, out_pay_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;

  logic         resp_vld;
  logic [7:0]   resp_byte;
  logic         pend_q, pend_d;
  logic [7:0]   pend_byte_q, pend_byte_d;
  logic         tx_start_q, tx_start_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         wait_busy_q, wait_busy_d;

  logic         tmo_en, tmo_expire;
  logic         len_bad, last_data, term_ok;

  assign tmo_en    = (state_q != ST_IDLE);
  assign len_bad   = ({1'b0, i_rx_data} + 9'd1) > 9'(g_MAX_PAYLOAD);
  assign last_data = (idx_q == lmax_q);
  assign term_ok   = (i_rx_data == BYTE_EOF);

  light_cmd_timeout #(
    .g_LIMIT (TLIM)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_rx_vld),
    .i_en     (tmo_en),
    .o_expire (tmo_expire)
  );

  // Next-state logic: moves only on a received byte, or back to idle on timeout.
  always_comb begin
    state_d = state_q;
    if (i_rx_vld) begin
      case (state_q)
        ST_IDLE: if (i_rx_data == BYTE_SOF) state_d = ST_CMD;
        ST_CMD:  state_d = ST_LEN;
        ST_LEN:  state_d = len_bad ? ST_IDLE : ST_DATA;
        ST_DATA: if (last_data) state_d = ST_TERM;
        ST_TERM: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath and strobe generation.
  always_comb begin
    cmd_d      = cmd_q;
    lmax_d     = lmax_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    cmd_vld_d  = 1'b0;
    out_cmd_d  = out_cmd_q;
    out_len_d  = out_len_q;
    out_pay_d  = out_pay_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    resp_vld   = 1'b0;
    resp_byte  = BYTE_ACK;
    if (i_rx_vld) begin
      case (state_q)
        ST_IDLE: if (i_rx_data == BYTE_SOF) shreg_d = '0;
        ST_CMD:  cmd_d = i_rx_data;
        ST_LEN: begin
          if (len_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            resp_vld   = 1'b1;
            resp_byte  = BYTE_NAK;
          end else begin
            lmax_d = i_rx_data[2:0];
            idx_d  = '0;
          end
        end
        ST_DATA: begin
          shreg_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          if (!last_data) idx_d = idx_q + 3'd1;
        end
        ST_TERM: begin
          resp_vld = 1'b1;
          if (term_ok) begin
            cmd_vld_d = 1'b1;
            out_cmd_d = cmd_q;
            out_len_d = len_from_l(lmax_q);
            out_pay_d = shreg_q;
            resp_byte = BYTE_ACK;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_TERM;
            resp_byte  = BYTE_NAK;
          end
        end
        default: ;
      endcase
    end else if (tmo_expire) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      resp_vld   = 1'b1;
      resp_byte  = BYTE_NAK;
    end
  end

  // Response queue of depth one. After a request, wait until the transmitter
  // has reported busy so the same idle window cannot launch a second byte.
  always_comb begin
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    wait_busy_d = wait_busy_q;
    if (wait_busy_q && i_tx_busy) wait_busy_d = 1'b0;
    if (pend_q && !i_tx_busy && !tx_start_q && !wait_busy_q) begin
      tx_start_d  = 1'b1;
      tx_data_d   = pend_byte_q;
      pend_d      = 1'b0;
      wait_busy_d = 1'b1;
    end
    // A fresh response replaces anything not yet sent.
    if (resp_vld) begin
      pend_d      = 1'b1;
      pend_byte_d = resp_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      lmax_q      <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      cmd_vld_q   <= 1'b0;
      out_cmd_q   <= '0;
      out_len_q   <= '0;
      out_pay_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      wait_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      lmax_q      <= lmax_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      cmd_vld_q   <= cmd_vld_d;
      out_cmd_q   <= out_cmd_d;
      out_len_q   <= out_len_d;
      out_pay_q   <= out_pay_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      wait_busy_q <= wait_busy_d;
    end
  end

  assign o_cmd_vld  = cmd_vld_q;
  assign o_cmd      = out_cmd_q;
  assign o_len      = out_len_q;
  assign o_payload  = out_pay_q;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;

endmodule

// File: tb/tb_light_cmd_parser.sv
// Testbench for light_cmd_parser: table of directed frames, hand-written
// timeout / busy / reset sequences, then a random byte stream checked
// against a frame-buffer reference model.
module tb_light_cmd_parser;

  localparam logic [7:0] SOF = 8'h4B;
  localparam logic [7:0] EOF = 8'h0D;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int MAXP = 8;
  localparam int TLIM = 1200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld = 1'b0;
  logic        tx_busy = 1'b0;
  logic        cmd_vld;
  logic [7:0]  cmd;
  logic [3:0]  len;
  logic [63:0] payload;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  tx_data;
  logic        tx_start;

  always #5 clk = ~clk;

  light_cmd_parser dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_vld   (rx_vld),
    .o_cmd_vld  (cmd_vld),
    .o_cmd      (cmd),
    .o_len      (len),
    .o_payload  (payload),
    .o_err      (err),
    .o_err_code (err_code),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .i_tx_busy  (tx_busy)
  );

  typedef struct packed {
    logic [7:0]  c;
    logic [3:0]  l;
    logic [63:0] p;
  } cmd_rec_t;

  cmd_rec_t   got_cmd[$];
  logic [1:0] got_err[$];
  int         got_err_cyc[$];
  logic [7:0] got_tx[$];

  cmd_rec_t   exp_cmd[$];
  logic [1:0] exp_err[$];
  logic [7:0] exp_tx[$];
  logic [7:0] fq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit force_busy = 1'b0;
  int busy_left = 0;

  always @(posedge clk) cyc++;

  // Event monitor
  always @(negedge clk) begin
    if (cmd_vld) got_cmd.push_back({cmd, len, payload});
    if (err) begin
      got_err.push_back(err_code);
      got_err_cyc.push_back(cyc);
    end
    if (tx_start) got_tx.push_back(tx_data);
  end

  // Transmitter model: busy for three cycles after each request
  always @(negedge clk) begin
    if (force_busy) begin
      tx_busy = 1'b1;
    end else if (tx_start) begin
      tx_busy = 1'b1;
      busy_left = 3;
    end else if (busy_left > 0) begin
      busy_left--;
      tx_busy = (busy_left != 0);
    end else begin
      tx_busy = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic clear_got();
    got_cmd.delete();
    got_err.delete();
    got_err_cyc.delete();
    got_tx.delete();
  endtask

  // Reference model: buffer bytes from SOF, decide by buffer length.
  task automatic model_byte(input logic [7:0] b);
    cmd_rec_t r;
    int l;
    if (fq.size() == 0) begin
      if (b == SOF) fq.push_back(b);
      return;
    end
    fq.push_back(b);
    if (fq.size() == 3) begin
      if (int'(b) + 1 > MAXP) begin
        exp_err.push_back(2'd1);
        exp_tx.push_back(NAK);
        fq.delete();
      end
    end else if (fq.size() > 3) begin
      l = int'(fq[2]);
      if (fq.size() == 5 + l) begin
        if (b == EOF) begin
          r.c = fq[1];
          r.l = 4'(l + 1);
          r.p = '0;
          for (int j = 0; j <= l; j++) r.p[j*8 +: 8] = fq[3+j];
          exp_cmd.push_back(r);
          exp_tx.push_back(ACK);
        end else begin
          exp_err.push_back(2'd2);
          exp_tx.push_back(NAK);
        end
        fq.delete();
      end
    end
  endtask

  typedef struct {
    logic [127:0] bytes;
    int           n;
    bit           e_vld;
    logic [7:0]   e_cmd;
    logic [3:0]   e_len;
    logic [63:0]  e_pay;
    logic [1:0]   e_err;
    int           n_tx;
    logic [7:0]   tx0;
    logic [7:0]   tx1;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] b, input int n, input bit v,
                              input logic [7:0] c, input logic [3:0] l, input logic [63:0] p,
                              input logic [1:0] e, input int ntx, input logic [7:0] t0,
                              input logic [7:0] t1);
    vec_t x;
    x.bytes = b; x.n = n; x.e_vld = v; x.e_cmd = c; x.e_len = l; x.e_pay = p;
    x.e_err = e; x.n_tx = ntx; x.tx0 = t0; x.tx1 = t1;
    return x;
  endfunction

  vec_t       vt[8];
  cmd_rec_t   last_cmd;
  logic [1:0] last_err;
  logic [127:0] bv;
  logic [7:0] stream[$];
  logic [7:0] rb;
  int kind, lv, t0, nmin;

  initial begin
    vt[0] = mk(128'h4B_00_00_45_0D, 5, 1, 8'h00, 4'd1, 64'h45, 2'd0, 1, ACK, 8'h00);
    vt[1] = mk(128'h4B_02_07_F1_00_00_05_00_00_00_00_0D, 12, 1, 8'h02, 4'd8,
               64'h00000000050000F1, 2'd0, 1, ACK, 8'h00);
    vt[2] = mk(128'h4B_0A_08_22_4B_02_00_33_0D, 9, 1, 8'h02, 4'd1, 64'h33, 2'd1, 2, NAK, ACK);
    vt[3] = mk(128'h4B_12_00_01_0C, 5, 0, 8'h00, 4'd0, 64'h0, 2'd2, 1, NAK, 8'h00);
    vt[4] = mk(128'h4B_00_00_45_0D, 5, 1, 8'h00, 4'd1, 64'h45, 2'd0, 1, ACK, 8'h00);
    vt[5] = mk(128'h4B_0A_01_4B_0D_0D, 6, 1, 8'h0A, 4'd2, 64'h0D4B, 2'd0, 1, ACK, 8'h00);
    vt[6] = mk(128'h55_0D_4B_12_00_FF_0D, 7, 1, 8'h12, 4'd1, 64'hFF, 2'd0, 1, ACK, 8'h00);
    vt[7] = mk(128'h4B_00_00_45_4B_00_00_46_0D, 9, 0, 8'h00, 4'd0, 64'h0, 2'd2, 1, NAK, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst cmd_vld", 64'(cmd_vld), 64'd0);
    chk("rst cmd", 64'(cmd), 64'd0);
    chk("rst len", 64'(len), 64'd0);
    chk("rst payload", payload, 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst err_code", 64'(err_code), 64'd0);
    chk("rst tx_data", 64'(tx_data), 64'd0);
    chk("rst tx_start", 64'(tx_start), 64'd0);
    rst_n = 1'b1;
    last_cmd = '0;
    last_err = 2'd0;

    // Directed frame table
    for (int v = 0; v < 8; v++) begin
      clear_got();
      bv = vt[v].bytes;
      for (int i = 0; i < vt[v].n; i++) send_byte(bv[(vt[v].n-1-i)*8 +: 8]);
      repeat (12) @(negedge clk);
      chk($sformatf("v%0d cmd count", v), 64'(got_cmd.size()), 64'(vt[v].e_vld));
      if (vt[v].e_vld && got_cmd.size() > 0) begin
        chk($sformatf("v%0d cmd", v), 64'(got_cmd[0].c), 64'(vt[v].e_cmd));
        chk($sformatf("v%0d len", v), 64'(got_cmd[0].l), 64'(vt[v].e_len));
        chk($sformatf("v%0d payload", v), got_cmd[0].p, vt[v].e_pay);
        last_cmd = {vt[v].e_cmd, vt[v].e_len, vt[v].e_pay};
      end
      chk($sformatf("v%0d cmd hold", v), 64'(cmd), 64'(last_cmd.c));
      chk($sformatf("v%0d len hold", v), 64'(len), 64'(last_cmd.l));
      chk($sformatf("v%0d payload hold", v), payload, last_cmd.p);
      chk($sformatf("v%0d err count", v), 64'(got_err.size()), 64'(vt[v].e_err != 2'd0));
      if (vt[v].e_err != 2'd0) begin
        if (got_err.size() > 0)
          chk($sformatf("v%0d err code", v), 64'(got_err[0]), 64'(vt[v].e_err));
        last_err = vt[v].e_err;
      end
      chk($sformatf("v%0d err_code hold", v), 64'(err_code), 64'(last_err));
      chk($sformatf("v%0d tx count", v), 64'(got_tx.size()), 64'(vt[v].n_tx));
      if (got_tx.size() > 0) chk($sformatf("v%0d tx0", v), 64'(got_tx[0]), 64'(vt[v].tx0));
      if (vt[v].n_tx > 1 && got_tx.size() > 1)
        chk($sformatf("v%0d tx1", v), 64'(got_tx[1]), 64'(vt[v].tx1));
    end

    // Timeout after CMD byte: error exactly TLIM clocks after it
    clear_got();
    send_byte(SOF);
    send_byte(8'h0A);
    t0 = cyc;
    repeat (1300) @(negedge clk);
    chk("tmo err count", 64'(got_err.size()), 64'd1);
    if (got_err.size() > 0) begin
      chk("tmo err code", 64'(got_err[0]), 64'd3);
      chk("tmo err delay", 64'(got_err_cyc[0] - t0), 64'(TLIM));
    end
    chk("tmo err_code hold", 64'(err_code), 64'd3);
    chk("tmo tx count", 64'(got_tx.size()), 64'd1);
    if (got_tx.size() > 0) chk("tmo tx", 64'(got_tx[0]), 64'(NAK));
    chk("tmo cmd count", 64'(got_cmd.size()), 64'd0);
    last_err = 2'd3;

    // Byte landing in the expiry cycle wins
    clear_got();
    send_byte(SOF);
    send_byte(8'h0A);
    t0 = cyc;
    while (cyc < t0 + TLIM - 2) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h45);
    send_byte(EOF);
    repeat (10) @(negedge clk);
    chk("edge err count", 64'(got_err.size()), 64'd0);
    chk("edge cmd count", 64'(got_cmd.size()), 64'd1);
    if (got_cmd.size() > 0) chk("edge cmd", 64'(got_cmd[0].c), 64'h0A);
    chk("edge tx count", 64'(got_tx.size()), 64'd1);
    if (got_tx.size() > 0) chk("edge tx", 64'(got_tx[0]), 64'(ACK));

    // Transmitter busy: NAK overwritten by ACK, single request after busy drops
    force_busy = 1'b1;
    @(negedge clk);
    clear_got();
    for (int i = 0; i < 5; i++) send_byte(i == 0 ? SOF : i == 1 ? 8'h12 : i == 2 ? 8'h00 :
                                          i == 3 ? 8'h01 : 8'h0C);
    for (int i = 0; i < 5; i++) send_byte(i == 0 ? SOF : i == 1 ? 8'h02 : i == 2 ? 8'h00 :
                                          i == 3 ? 8'h77 : EOF);
    repeat (20) @(negedge clk);
    chk("busy tx held", 64'(got_tx.size()), 64'd0);
    force_busy = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy tx count", 64'(got_tx.size()), 64'd1);
    if (got_tx.size() > 0) chk("busy tx", 64'(got_tx[0]), 64'(ACK));
    chk("busy cmd count", 64'(got_cmd.size()), 64'd1);

    // Reset in the middle of DATA
    send_byte(SOF);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid rst cmd_vld", 64'(cmd_vld), 64'd0);
    chk("mid rst cmd", 64'(cmd), 64'd0);
    chk("mid rst len", 64'(len), 64'd0);
    chk("mid rst payload", payload, 64'd0);
    chk("mid rst err", 64'(err), 64'd0);
    chk("mid rst err_code", 64'(err_code), 64'd0);
    chk("mid rst tx_data", 64'(tx_data), 64'd0);
    chk("mid rst tx_start", 64'(tx_start), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_got();
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(EOF);
    repeat (10) @(negedge clk);
    chk("post rst cmd count", 64'(got_cmd.size()), 64'd0);
    chk("post rst err count", 64'(got_err.size()), 64'd0);
    chk("post rst tx count", 64'(got_tx.size()), 64'd0);
    send_byte(SOF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h45);
    send_byte(EOF);
    repeat (10) @(negedge clk);
    chk("post rst frame", 64'(got_cmd.size()), 64'd1);
    if (got_cmd.size() > 0) chk("post rst payload", got_cmd[0].p, 64'h45);

    // Random stream against the reference model
    clear_got();
    fq.delete();
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 8) begin
        for (int i = 0; i < 2; i++) begin
          rb = 8'($urandom_range(0, 255));
          if (rb == SOF) rb = 8'h00;
          stream.push_back(rb);
        end
      end else begin
        stream.push_back(SOF);
        lv = $urandom_range(0, 3);
        stream.push_back(lv == 0 ? 8'h00 : lv == 1 ? 8'h02 : lv == 2 ? 8'h0A : 8'h12);
        if (kind == 6) begin
          stream.push_back(8'($urandom_range(8, 255)));
        end else begin
          lv = $urandom_range(0, 7);
          stream.push_back(8'(lv));
          for (int j = 0; j <= lv; j++) stream.push_back(8'($urandom_range(0, 255)));
          if (kind == 7) begin
            rb = 8'($urandom_range(0, 255));
            if (rb == EOF) rb = 8'h4B;
            stream.push_back(rb);
          end else begin
            stream.push_back(EOF);
          end
        end
      end
    end
    foreach (stream[i]) begin
      model_byte(stream[i]);
      send_byte(stream[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("rnd cmd count", 64'(got_cmd.size()), 64'(exp_cmd.size()));
    chk("rnd err count", 64'(got_err.size()), 64'(exp_err.size()));
    chk("rnd tx count", 64'(got_tx.size()), 64'(exp_tx.size()));
    nmin = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("rnd cmd%0d", i), 64'(got_cmd[i].c), 64'(exp_cmd[i].c));
      chk($sformatf("rnd len%0d", i), 64'(got_cmd[i].l), 64'(exp_cmd[i].l));
      chk($sformatf("rnd pay%0d", i), got_cmd[i].p, exp_cmd[i].p);
    end
    nmin = (got_err.size() < exp_err.size()) ? got_err.size() : exp_err.size();
    for (int i = 0; i < nmin; i++)
      chk($sformatf("rnd err%0d", i), 64'(got_err[i]), 64'(exp_err[i]));
    nmin = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
    for (int i = 0; i < nmin; i++)
      chk($sformatf("rnd tx%0d", i), 64'(got_tx[i]), 64'(exp_tx[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
